// File: rtl/hilo_pkg.sv
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared definitions for the HI/LO unit: op codes, divider
//                state encoding and the data width.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package hilo_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] c_op_none = 3'd0;
    localparam logic [2:0] c_op_mul  = 3'd1;
    localparam logic [2:0] c_op_mthi = 3'd2;
    localparam logic [2:0] c_op_mtlo = 3'd3;
    localparam logic [2:0] c_op_div  = 3'd4;
    localparam logic [2:0] c_op_divu = 3'd5;
    localparam logic [2:0] c_op_madd = 3'd6;
    localparam logic [2:0] c_op_msub = 3'd7;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_div   = 2'd1;
    localparam logic [1:0] c_st_fixup = 2'd2;

    // Conditional two's-complement negation, used for |x| and sign fixup.
    function automatic logic [DATA_W-1:0] cneg(input logic [DATA_W-1:0] v,
                                               input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_divider.sv
// ============================================================================
//  Module      : hilo_divider
//  Description : Iterative restoring divider, one quotient bit per cycle,
//                with signed operand conditioning and result sign fixup.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_divider
    import hilo_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic             r_qneg;
    logic             r_rneg;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;

    // The dividend is shifted out of r_quot as quotient bits shift in.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};
    assign w_qbit  = ~w_trial[WIDTH];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= c_st_idle;
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        r_quot    <= cneg(i_dividend, i_signed & i_dividend[WIDTH-1]);
                        r_divisor <= cneg(i_divisor, i_signed & i_divisor[WIDTH-1]);
                        r_rem     <= '0;
                        r_qneg    <= i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                        r_rneg    <= i_signed & i_dividend[WIDTH-1];
                        r_count   <= '0;
                        r_state   <= c_st_div;
                    end
                end
                c_st_div: begin
                    r_rem   <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quot  <= {r_quot[WIDTH-2:0], w_qbit};
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        r_state <= c_st_fixup;
                    end
                end
                c_st_fixup: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != c_st_idle);
    assign o_done      = (r_state == c_st_fixup);
    assign o_quotient  = cneg(r_quot, r_qneg);
    assign o_remainder = cneg(r_rem, r_rneg);

endmodule

`default_nettype wire

// File: rtl/hilo_unit.sv
// ============================================================================
//  Module      : hilo_unit
//  Description : Architectural HI/LO register pair with MUL/MTHI/MTLO writes
//                and an iterative DIV/DIVU engine. Optional MADD/MSUB are
//                built when HILO_MADD_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_unit
    import hilo_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              OpValid,
    input  logic [2:0]        HiLoOp,
    input  logic [63:0]       ALU64Result,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              Stall,
    output logic [DATA_W-1:0] HiOut,
    output logic [DATA_W-1:0] LoOut,
    output logic              DivByZero
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_dbz;

    logic              w_busy;
    logic              w_done;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;
    logic              w_accept;
    logic              w_is_div;
    logic              w_b_zero;
    logic              w_div_start;

    assign w_accept    = OpValid & ~w_busy;
    assign w_is_div    = (HiLoOp == c_op_div) || (HiLoOp == c_op_divu);
    assign w_b_zero    = (B == '0);
    assign w_div_start = w_accept & w_is_div & ~w_b_zero;

`ifdef HILO_MADD_EN
    logic [63:0] w_acc;
    // HiLoOp[0] separates MSUB (7) from MADD (6).
    assign w_acc = HiLoOp[0] ? ({r_hi, r_lo} - ALU64Result)
                             : ({r_hi, r_lo} + ALU64Result);
`endif

    hilo_divider #(
        .WIDTH (DATA_W)
    ) u_divider (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_start     (w_div_start),
        .i_signed    (HiLoOp == c_op_div),
        .i_dividend  (A),
        .i_divisor   (B),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else begin
            r_dbz <= w_accept & w_is_div & w_b_zero;
            if (w_done) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end else if (w_accept) begin
                case (HiLoOp)
                    c_op_mul:  {r_hi, r_lo} <= ALU64Result;
                    c_op_mthi: r_hi <= ALU64Result[63:32];
                    c_op_mtlo: r_lo <= ALU64Result[31:0];
`ifdef HILO_MADD_EN
                    c_op_madd,
                    c_op_msub: {r_hi, r_lo} <= w_acc;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign Stall     = w_busy;
    assign HiOut     = r_hi;
    assign LoOut     = r_lo;
    assign DivByZero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Self-checking bench for hilo_unit against a behavioural
//                HI/LO model (honours HILO_MADD_EN).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        OpValid = 1'b0;
    logic [2:0]  HiLoOp = 3'd0;
    logic [63:0] ALU64Result = 64'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Stall;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        DivByZero;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    hilo_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .OpValid     (OpValid),
        .HiLoOp      (HiLoOp),
        .ALU64Result (ALU64Result),
        .A           (A),
        .B           (B),
        .Stall       (Stall),
        .HiOut       (HiOut),
        .LoOut       (LoOut),
        .DivByZero   (DivByZero)
    );

    always #5 Clk = ~Clk;

    // Architectural effect of one accepted op on the model HI/LO.
    task automatic model_op(input logic [2:0] op, input logic [63:0] alu,
                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        case (op)
            3'd1: {m_hi, m_lo} = alu;
            3'd2: m_hi = alu[63:32];
            3'd3: m_lo = alu[31:0];
            3'd4, 3'd5: begin
                if (b != 32'd0) begin
                    if (op == 3'd4) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = {32'd0, a};
                        sb = {32'd0, b};
                    end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
`ifdef HILO_MADD_EN
            3'd6: {m_hi, m_lo} = {m_hi, m_lo} + alu;
            3'd7: {m_hi, m_lo} = {m_hi, m_lo} - alu;
`endif
            default: ;
        endcase
    endtask

    // Presents one op for one edge, then waits out any stall (bounded).
    // hold_ok reports whether HI/LO kept the pre-op model value while stalled.
    task automatic apply(input logic [2:0] op, input logic [63:0] alu,
                         input logic [31:0] a, input logic [31:0] b,
                         output int stall_cycles, output bit hold_ok);
        OpValid = 1'b1; HiLoOp = op; ALU64Result = alu; A = a; B = b;
        @(posedge Clk); #1;
        OpValid = 1'b0; HiLoOp = 3'd0;
        stall_cycles = 0;
        hold_ok = 1'b1;
        while (Stall && stall_cycles < 100) begin
            if (HiOut !== m_hi || LoOut !== m_lo) hold_ok = 1'b0;
            @(posedge Clk); #1;
            stall_cycles++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #12;
        n_vec++;
        if (Stall !== 1'b0 || DivByZero !== 1'b0 || HiOut !== 32'd0 || LoOut !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: stall=%b dbz=%b hi=%h lo=%h, want 0 0 0 0",
                     Stall, DivByZero, HiOut, LoOut);
        end
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_moves();
        int sc; bit h;
        apply(3'd1, 64'h00000001_FFFFFFFE, 32'd0, 32'd0, sc, h);
        model_op(3'd1, 64'h00000001_FFFFFFFE, 32'd0, 32'd0);
        n_vec++;
        if (HiOut !== 32'h00000001 || LoOut !== 32'hFFFFFFFE || sc != 0) begin
            n_bad++;
            $display("FAIL mul: hi=%h lo=%h stall=%0d, want 00000001 fffffffe 0", HiOut, LoOut, sc);
        end
        apply(3'd2, 64'h12345678_AAAAAAAA, 32'd0, 32'd0, sc, h);
        model_op(3'd2, 64'h12345678_AAAAAAAA, 32'd0, 32'd0);
        n_vec++;
        if (HiOut !== 32'h12345678 || LoOut !== 32'hFFFFFFFE) begin
            n_bad++;
            $display("FAIL mthi: hi=%h lo=%h, want 12345678 fffffffe", HiOut, LoOut);
        end
        apply(3'd3, 64'hBBBBBBBB_CAFEF00D, 32'd0, 32'd0, sc, h);
        model_op(3'd3, 64'hBBBBBBBB_CAFEF00D, 32'd0, 32'd0);
        n_vec++;
        if (HiOut !== 32'h12345678 || LoOut !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL mtlo: hi=%h lo=%h, want 12345678 cafef00d", HiOut, LoOut);
        end
    endtask

    task automatic test_div_signed();
        int sc; bit h;
        apply(3'd4, 64'd0, 32'hFFFFFFF9, 32'd2, sc, h);
        n_vec++;
        if (sc != 33 || !h) begin
            n_bad++;
            $display("FAIL div_stall: cycles=%0d hold=%b, want 33 1", sc, h);
        end
        n_vec++;
        if (LoOut !== 32'hFFFFFFFD || HiOut !== 32'hFFFFFFFF) begin
            n_bad++;
            $display("FAIL div_neg7_by_2: lo=%h hi=%h, want fffffffd ffffffff", LoOut, HiOut);
        end
        model_op(3'd4, 64'd0, 32'hFFFFFFF9, 32'd2);
    endtask

    task automatic test_divu_ignore();
        int sc;
        OpValid = 1'b1; HiLoOp = 3'd5; A = 32'hFFFFFFFF; B = 32'h10;
        @(posedge Clk); #1;
        // An MTLO held valid throughout the stall must never land.
        HiLoOp = 3'd3; ALU64Result = 64'hDEADBEEF_DEADBEEF;
        sc = 0;
        while (Stall && sc < 100) begin
            @(posedge Clk); #1;
            sc++;
        end
        OpValid = 1'b0; HiLoOp = 3'd0;
        model_op(3'd5, 64'd0, 32'hFFFFFFFF, 32'h10);
        n_vec++;
        if (LoOut !== 32'h0FFFFFFF || HiOut !== 32'h0000000F || sc != 33) begin
            n_bad++;
            $display("FAIL divu_ignore: lo=%h hi=%h cycles=%0d, want 0fffffff 0000000f 33",
                     LoOut, HiOut, sc);
        end
        @(posedge Clk); #1;
        n_vec++;
        if (LoOut !== 32'h0FFFFFFF) begin
            n_bad++;
            $display("FAIL divu_after_idle: lo=%h, want 0fffffff", LoOut);
        end
    endtask

    task automatic test_div_boundaries();
        int sc; bit h;
        apply(3'd4, 64'd0, 32'h00001234, 32'd0, sc, h);
        n_vec++;
        if (DivByZero !== 1'b1 || Stall !== 1'b0 || sc != 0 || HiOut !== m_hi || LoOut !== m_lo) begin
            n_bad++;
            $display("FAIL div_by_zero: dbz=%b stall=%b hi=%h lo=%h, want 1 0 %h %h",
                     DivByZero, Stall, HiOut, LoOut, m_hi, m_lo);
        end
        @(posedge Clk); #1;
        n_vec++;
        if (DivByZero !== 1'b0) begin
            n_bad++;
            $display("FAIL dbz_pulse_width: dbz=%b, want 0", DivByZero);
        end
        apply(3'd4, 64'd0, 32'h80000000, 32'hFFFFFFFF, sc, h);
        model_op(3'd4, 64'd0, 32'h80000000, 32'hFFFFFFFF);
        n_vec++;
        if (LoOut !== 32'h80000000 || HiOut !== 32'd0 || DivByZero !== 1'b0) begin
            n_bad++;
            $display("FAIL div_min_by_m1: lo=%h hi=%h dbz=%b, want 80000000 00000000 0",
                     LoOut, HiOut, DivByZero);
        end
    endtask

    task automatic test_reset_mid_div();
        int sc; bit h;
        OpValid = 1'b1; HiLoOp = 3'd4; A = 32'h7FFFFFFF; B = 32'd3;
        @(posedge Clk); #1;
        OpValid = 1'b0; HiLoOp = 3'd0;
        repeat (9) begin
            @(posedge Clk); #1;
        end
        #2 Reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_vec++;
        if (Stall !== 1'b0 || HiOut !== 32'd0 || LoOut !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_div: stall=%b hi=%h lo=%h, want 0 0 0", Stall, HiOut, LoOut);
        end
        #2 Reset = 1'b1;
        @(posedge Clk); #1;
        apply(3'd6, 64'd5, 32'd0, 32'd0, sc, h);
        model_op(3'd6, 64'd5, 32'd0, 32'd0);
        n_vec++;
        if (LoOut !== m_lo || HiOut !== m_hi || sc != 0) begin
            n_bad++;
            $display("FAIL madd_after_reset: lo=%h hi=%h, want %h %h", LoOut, HiOut, m_lo, m_hi);
        end
    endtask

    task automatic test_random();
        int sc; bit h;
        logic [2:0]  op;
        logic [63:0] alu;
        logic [31:0] a, b;
        int exp_sc;
        bit exp_dbz;
        for (int i = 0; i < 150; i++) begin
            op  = 3'($urandom_range(0, 7));
            alu = {$urandom, $urandom};
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 100));
                2:       b = -32'($urandom_range(1, 100));
                default: b = $urandom;
            endcase
            exp_sc  = ((op == 3'd4 || op == 3'd5) && b != 32'd0) ? 33 : 0;
            exp_dbz = (op == 3'd4 || op == 3'd5) && b == 32'd0;
            apply(op, alu, a, b, sc, h);
            model_op(op, alu, a, b);
            n_vec++;
            if (HiOut !== m_hi || LoOut !== m_lo || sc != exp_sc || !h || DivByZero !== exp_dbz) begin
                n_bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h cyc=%0d hold=%b dbz=%b, want %h %h %0d 1 %b",
                         i, op, a, b, HiOut, LoOut, sc, h, DivByZero, m_hi, m_lo, exp_sc, exp_dbz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_moves();
        test_div_signed();
        test_divu_ignore();
        test_div_boundaries();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
